// File: rtl/packed_cmd_unpacker.sv
// Unpacks {write_not_read, addr[22:0], data[7:0]} commands into single-byte memory accesses.
// Optional read timeout with a synthetic 0xFFFF_FFFF response: define PACKED_CMD_UNPACKER_TIMEOUT_EN.
module packed_cmd_unpacker #(
  parameter int unsigned timeout_cycles_p = 1024,
  parameter int unsigned timeout_width_p  = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_v_i,
  output logic        cmd_ready_o,
  output logic [31:0] resp_data_o,
  output logic        resp_v_o,
  input  logic        resp_ready_i,
  output logic [22:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_w_o,
  output logic        mem_v_o,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_v_i,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRdata, StResp} state_e;

  state_e      state_q, state_d;
  logic        mem_w_q, mem_w_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic [31:0] resp_data_q, resp_data_d;

`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
  localparam logic [timeout_width_p-1:0] CntLast = timeout_width_p'(timeout_cycles_p - 1);
  logic [timeout_width_p-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_w_d     = mem_w_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    resp_data_d = resp_data_q;
`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_v_i) begin
          mem_w_d    = cmd_data_i[31];
          mem_addr_d = cmd_data_i[30:8];
          mem_data_d = cmd_data_i[7:0];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (mem_ready_i) begin
          if (mem_w_q) begin
            state_d = StIdle;
          end else begin
            state_d = StWaitRdata;
`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StWaitRdata: begin
        if (mem_v_i) begin
          resp_data_d = {24'b0, mem_data_i};
          state_d     = StResp;
        end
`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
        // Counter holds the number of completed empty wait cycles.
        else if (cnt_q == CntLast) begin
          resp_data_d = 32'hFFFF_FFFF;
          err_d       = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      resp_data_q <= '0;
`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      resp_data_q <= resp_data_d;
`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Valids decode straight from state so reset drops them asynchronously.
  assign cmd_ready_o = (state_q == StIdle);
  assign mem_v_o     = (state_q == StIssue);
  assign resp_v_o    = (state_q == StResp);
  assign mem_w_o     = mem_w_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign resp_data_o = resp_data_q;
`ifdef PACKED_CMD_UNPACKER_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

  // Simulation checks; immediate assertions carry no hardware.
  always_ff @(posedge clk_i) begin
    assert (timeout_cycles_p >= 1 && (timeout_width_p >= 32 ||
            (64'd1 << timeout_width_p) > 64'(timeout_cycles_p)))
      else $warning("packed_cmd_unpacker: bad timeout parameters");
    if (reset_n_i) begin
      assert (!(mem_v_i && state_q != StWaitRdata))
        else $warning("packed_cmd_unpacker: mem_v_i dropped outside read wait");
      assert (!(cmd_v_i && $isunknown(cmd_data_i)))
        else $warning("packed_cmd_unpacker: X on cmd_data_i with cmd_v_i");
    end
  end

endmodule

// File: doc/packed_cmd_unpacker.md
Name: packed_cmd_unpacker

Overview:
- Downstream consumer of the packed 32-bit command stream {write_not_read, addr[22:0], data[7:0]} produced by the AXI-lite store packer.
- Decodes each command into a single-byte access on a simple valid/ready memory port.
- For reads, returns the byte zero-extended to 32 bits on the response stream; writes produce no response.
- Strictly one command in flight, which matches the packer's one-outstanding-request contract.

Parameters:
- timeout_cycles_p, 1024, read-wait cycles before a synthetic error response (used only with the optional feature; must be ≥1)
- timeout_width_p, 16, timeout counter width; must satisfy 2^timeout_width_p > timeout_cycles_p

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- cmd_data_i  in  32  packed command
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- resp_data_o  out  32  read response data
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response ready
- mem_addr_o  out  23  byte address
- mem_data_o  out  8  write byte
- mem_w_o  out  1  1=write, 0=read
- mem_v_o  out  1  memory request valid
- mem_ready_i  in  1  memory request ready
- mem_data_i  in  8  read return byte
- mem_v_i  in  1  read return valid; one cycle, no backpressure
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset is asynchronous on reset_n_i falling and is released synchronously to clk_i.
- Reset values:
  - state = e_idle.
  - All output data registers = 0.
  - mem_v_o = 0, resp_v_o = 0, err_o = 0.
  - cmd_ready_o = 1, since it follows e_idle.
- States: e_idle, e_issue, e_wait_rdata, e_resp.
- e_idle:
  - cmd_ready_o = 1.
  - On cmd_v_i & cmd_ready_o, register:
    - mem_w_o = cmd[31]
    - mem_addr_o = cmd[30:8]
    - mem_data_o = cmd[7:0]
  - Then go to e_issue.
- e_issue:
  - mem_v_o = 1, with addr/data/w stable until mem_ready_i.
  - On handshake, a write goes to e_idle and a read goes to e_wait_rdata.
  - cmd_ready_o = 0.
- e_wait_rdata:
  - On mem_v_i, register resp_data_o = {24'b0, mem_data_i} and go to e_resp.
  - Read data never arrives in the same cycle as the request handshake (memory latency ≥1).
- e_resp:
  - resp_v_o = 1, with resp_data_o stable until resp_ready_i.
  - On handshake, go to e_idle.
- Latency:
  - Command accept at cycle N → mem_v_o at N+1.
  - mem_v_i at cycle M → resp_v_o at M+1.
  - Minimum back-to-back write throughput is 1 command per 2 cycles.
- mem_v_i outside e_wait_rdata is dropped; the sim-only assertion fires.
- cmd_v_i while not idle is held off (cmd_ready_o = 0); the command is not lost.
- Reset mid-operation:
  - Any state returns immediately to e_idle.
  - mem_v_o and resp_v_o drop asynchronously.
  - The pending access is abandoned with no response.
- Sim-only assertions:
  - mem_v_i outside e_wait_rdata.
  - X on cmd_data_i while cmd_v_i.

Optional Feature:
- Macro: PACKED_CMD_UNPACKER_TIMEOUT_EN
- When defined:
  - A counter clears on entry to e_wait_rdata and increments each cycle without mem_v_i.
  - When the counter reaches timeout_cycles_p, resp_data_o = 32'hFFFF_FFFF, err_o sets (sticky until reset) and the state goes to e_resp.
  - A late mem_v_i after timeout is dropped and fires the assertion.
- When undefined:
  - No counter is built and err_o is tied 0.
  - e_wait_rdata waits indefinitely.

Test Plan:
- Write: cmd 0x8012_3456, mem_ready_i=1 → next cycle mem_v_o=1, mem_w_o=1, mem_addr_o=0x001234, mem_data_o=0x56; no resp_v_o; cmd_ready_o high again 2 cycles after accept.
- Read: cmd 0x0000_AB00; mem returns 0x7F 3 cycles after request handshake → mem_addr_o=0x0000AB, mem_w_o=0; resp_v_o one cycle after mem_v_i with resp_data_o=0x0000_007F.
- Backpressure:
  - mem_ready_i low 5 cycles: mem_v_o and fields held stable.
  - resp_ready_i low 4 cycles: resp_v_o and data held stable.
  - cmd_ready_o=0 throughout; a second queued cmd is accepted only after the response handshake.
- Reset mid-read: reset_n_i low while in e_wait_rdata → outputs at reset values asynchronously; the following cmd 0x8000_0111 executes normally (addr 0x000001, data 0x11).
- Spurious mem_v_i in e_idle → ignored, no resp_v_o, assertion fires.
- Timeout (macro on, timeout_cycles_p=8): read with no mem_v_i → resp_data_o=0xFFFF_FFFF, err_o=1 at cycle 8 of the wait; macro off → still waiting at cycle 100.
